// File: rtl/picomips_pkg.sv
// Shared types and constants for the picoMIPS accumulator core.
// Opcode encoding, FSM state encoding and the Q2.2 multiply shift.
package picomips_pkg;

  typedef enum logic [2:0] {
    OP_HEI  = 3'b000,
    OP_LSW  = 3'b001,
    OP_MULI = 3'b010,
    OP_ATR  = 3'b011,
    OP_RTA  = 3'b100,
    OP_ADD  = 3'b101,
    OP_ADDI = 3'b110,
    OP_BRA  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_t;

  // MULI immediates are Q2.2, so the raw product carries two fraction bits.
  localparam int QSHIFT = 2;

endpackage

// File: rtl/picomips_alu.sv
// Combinational accumulator datapath for LSW/RTA/ADD/ADDI/MULI.
// Define PICOMIPS_SAT_EN to clamp ADD/ADDI/MULI overflow instead of wrapping.
module picomips_alu
  import picomips_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_t                   op,
  input  logic [4:0]                operand,
  input  logic signed [DATA_W-1:0]  acc,
  input  logic signed [DATA_W-1:0]  reg_val,
  input  logic signed [DATA_W-1:0]  sw,
  output logic signed [DATA_W-1:0]  result
);

`ifdef PICOMIPS_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Wide enough for the full acc * imm5 product and any single-step sum.
  localparam int EXT_W = DATA_W + 6;

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [4:0]       imm;
  logic signed [EXT_W-1:0] acc_x;
  logic signed [EXT_W-1:0] reg_x;
  logic signed [EXT_W-1:0] imm_x;
  logic signed [EXT_W-1:0] wide;

  assign imm   = operand;
  assign acc_x = EXT_W'(acc);
  assign reg_x = EXT_W'(reg_val);
  assign imm_x = EXT_W'(imm);

  always_comb begin
    wide = acc_x;
    case (op)
      OP_LSW:  wide = EXT_W'(sw);
      OP_RTA:  wide = reg_x;
      OP_ADD:  wide = acc_x + reg_x;
      OP_ADDI: wide = acc_x + (imm_x <<< 1);
      OP_MULI: wide = (acc_x * imm_x) >>> QSHIFT;
      default: wide = acc_x;
    endcase
  end

  always_comb begin
    result = wide[DATA_W-1:0];
    if (SAT_EN && (wide > EXT_W'(MAX_V)))
      result = MAX_V;
    else if (SAT_EN && (wide < EXT_W'(MIN_V)))
      result = MIN_V;
  end

endmodule

// File: rtl/picomips_core.sv
// picoMIPS 8-opcode accumulator core: FSM, register file and instruction memory.
// Overflow behaviour of ADD/ADDI/MULI is selected by PICOMIPS_SAT_EN (see picomips_alu).
module picomips_core
  import picomips_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NREGS      = 4,
  parameter int PROG_DEPTH = 32,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Run,
  input  logic              Go,
  input  logic [DATA_W-1:0] SW,
  input  logic              ProgWe,
  input  logic [PC_W-1:0]   ProgAddr,
  input  logic [7:0]        ProgData,
  output logic [DATA_W-1:0] LED,
  output logic [PC_W-1:0]   Pc,
  output logic              Busy,
  output logic              Waiting,
  output state_t            DbgState
);

  localparam int RS_W = $clog2(NREGS);

  logic [7:0]               imem [PROG_DEPTH];
  logic [DATA_W-1:0]        regs [NREGS];
  state_t                   state;
  logic [7:0]               ir;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] alu_res;
  opcode_t                  op;
  logic [4:0]               operand;
  logic [RS_W-1:0]          rsel;
  logic                     acc_we;

  assign op       = opcode_t'(ir[7:5]);
  assign operand  = ir[4:0];
  assign rsel     = operand[RS_W-1:0];
  assign LED      = acc;
  assign DbgState = state;

  always_comb begin
    acc_we = 1'b0;
    case (op)
      OP_LSW, OP_MULI, OP_RTA, OP_ADD, OP_ADDI: acc_we = 1'b1;
      default:                                  acc_we = 1'b0;
    endcase
  end

  picomips_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op),
    .operand (operand),
    .acc     (acc),
    .reg_val (regs[rsel]),
    .sw      (SW),
    .result  (alu_res)
  );

  // Program memory is deliberately outside reset so a loaded program survives it.
  always_ff @(posedge Clock) begin
    if (ProgWe)
      imem[ProgAddr] <= ProgData;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (state == ST_WRITE && op == OP_ATR) begin
      regs[rsel] <= acc;
    end
  end

  // HEI handshake: the core holds in EXEC while Go differs from operand[0];
  // Waiting rises after the first stalled edge and drops on the edge Go matches.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      ir      <= '0;
      acc     <= '0;
      Pc      <= '0;
      Busy    <= 1'b0;
      Waiting <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Run) begin
            state <= ST_FETCH;
            Busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir    <= imem[Pc];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op == OP_HEI && Go != operand[0]) begin
            Waiting <= 1'b1;
          end else begin
            Waiting <= 1'b0;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (acc_we)
            acc <= alu_res;
          Pc <= (op == OP_BRA) ? operand[PC_W-1:0] : Pc + 1'b1;
          if (Run) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picomips_core.sv
// Directed bench for picomips_core: reset, arithmetic, HEI handshake, branch/wrap, Run stop.
// LED results for the register test are staged through an expected queue.
module tb_picomips_core;
  import picomips_pkg::*;

  logic       Clock;
  logic       nReset;
  logic       Run;
  logic       Go;
  logic [7:0] SW;
  logic       ProgWe;
  logic [4:0] ProgAddr;
  logic [7:0] ProgData;
  logic [7:0] LED;
  logic [4:0] Pc;
  logic       Busy;
  logic       Waiting;
  state_t     DbgState;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  picomips_core #(.DATA_W(8), .NREGS(4), .PROG_DEPTH(32)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Run      (Run),
    .Go       (Go),
    .SW       (SW),
    .ProgWe   (ProgWe),
    .ProgAddr (ProgAddr),
    .ProgData (ProgData),
    .LED      (LED),
    .Pc       (Pc),
    .Busy     (Busy),
    .Waiting  (Waiting),
    .DbgState (DbgState)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Driver tasks: everything is driven and sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic prog_write(input logic [4:0] addr, input logic [7:0] data);
    ProgWe   = 1'b1;
    ProgAddr = addr;
    ProgData = data;
    tick(1);
    ProgWe   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_led(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(LED), 32'(e));
    end
  endtask

  initial begin
    Run = 1'b0; Go = 1'b0; SW = '0; ProgWe = 1'b0; ProgAddr = '0; ProgData = '0;
    nReset = 1'b0;
    tick(1);
    for (int i = 0; i < 32; i++) prog_write(5'(i), 8'hC0);  // ADDI 0 filler

    // Reset state with Run already high
    Run = 1'b1;
    tick(1);
    check("rst_led",   32'(LED),      32'd0);
    check("rst_pc",    32'(Pc),       32'd0);
    check("rst_busy",  32'(Busy),     32'd0);
    check("rst_wait",  32'(Waiting),  32'd0);
    check("rst_state", 32'(DbgState), 32'(ST_IDLE));

    // LSW; MULI 3 with SW=40
    prog_write(5'd0, 8'h20);
    prog_write(5'd1, 8'h43);
    SW = 8'd40;
    nReset = 1'b1;
    tick(1);
    check("rel_busy",  32'(Busy),     32'd1);
    check("rel_state", 32'(DbgState), 32'(ST_FETCH));
    tick(3);
    check("lsw_led",   32'(LED),      32'd40);
    tick(3);
    check("muli3_led", 32'(LED),      32'd30);
    check("muli3_pc",  32'(Pc),       32'd2);

    // MULI 30 (Q2.2 -0.5)
    nReset = 1'b0;
    prog_write(5'd1, 8'h5E);
    nReset = 1'b1;
    tick(7);
    check("muli30_led", 32'(LED), 32'h0EC);

    // LSW; ATR 2; ADDI 10; ADD 2; RTA 2 with SW=25
    nReset = 1'b0;
    prog_write(5'd0, 8'h20);
    prog_write(5'd1, 8'h62);
    prog_write(5'd2, 8'hCA);
    prog_write(5'd3, 8'hA2);
    prog_write(5'd4, 8'h82);
    SW = 8'd25;
    exp_q.push_back(8'd25);
    exp_q.push_back(8'd25);
    exp_q.push_back(8'd45);
    exp_q.push_back(8'd70);
    exp_q.push_back(8'd25);
    nReset = 1'b1;
    tick(4);
    check_led("reg_lsw");
    for (int k = 1; k < 5; k++) begin
      tick(3);
      check_led($sformatf("reg_step%0d", k));
    end
    check("reg_pc", 32'(Pc), 32'd5);

    // Overflow: SW=120, LSW; ADDI 10
    nReset = 1'b0;
    prog_write(5'd0, 8'h20);
    prog_write(5'd1, 8'hCA);
    SW = 8'd120;
    nReset = 1'b1;
    tick(7);
`ifdef PICOMIPS_SAT_EN
    check("ovf_led", 32'(LED), 32'h07F);
`else
    check("ovf_led", 32'(LED), 32'h08C);
`endif

    // HEI 1 stalls until Go=1
    nReset = 1'b0;
    prog_write(5'd0, 8'h01);
    Go = 1'b0;
    nReset = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hei_wait%0d", i), 32'(Waiting), 32'd1);
      check($sformatf("hei_pc%0d", i),   32'(Pc),      32'd0);
      tick(1);
    end
    Go = 1'b1;
    tick(1);
    check("hei_wait_clr", 32'(Waiting),  32'd0);
    check("hei_state",    32'(DbgState), 32'(ST_WRITE));
    check("hei_pc_hold",  32'(Pc),       32'd0);
    tick(1);
    check("hei_pc_inc",   32'(Pc),       32'd1);
    check("hei_led",      32'(LED),      32'd0);
    Go = 1'b0;

    // Sequential wrap 31 -> 0
    nReset = 1'b0;
    prog_write(5'd0,  8'hFE);
    prog_write(5'd30, 8'hC1);
    prog_write(5'd31, 8'hC1);
    nReset = 1'b1;
    tick(4);
    check("wrap_pc30", 32'(Pc),  32'd30);
    tick(3);
    check("wrap_pc31", 32'(Pc),  32'd31);
    check("wrap_led2", 32'(LED), 32'd2);
    tick(3);
    check("wrap_pc0",  32'(Pc),  32'd0);
    check("wrap_led4", 32'(LED), 32'd4);

    // BRA 0 at the last address, then Run drops mid-loop
    nReset = 1'b0;
    prog_write(5'd31, 8'hE0);
    nReset = 1'b1;
    tick(4);
    check("bra_pc30", 32'(Pc),  32'd30);
    tick(3);
    check("bra_pc31", 32'(Pc),  32'd31);
    tick(3);
    check("bra_pc0",  32'(Pc),  32'd0);
    check("bra_led",  32'(LED), 32'd2);
    tick(1);
    Run = 1'b0;
    tick(2);
    check("stop_busy",  32'(Busy),     32'd0);
    check("stop_state", 32'(DbgState), 32'(ST_IDLE));
    check("stop_pc",    32'(Pc),       32'd30);
    tick(3);
    check("stop_pc_hold",   32'(Pc),   32'd30);
    check("stop_busy_hold", 32'(Busy), 32'd0);

    // Asynchronous reset in the middle of a WRITE
    nReset = 1'b0;
    Run = 1'b1;
    prog_write(5'd0, 8'h20);
    prog_write(5'd1, 8'hCA);
    SW = 8'd55;
    nReset = 1'b1;
    tick(4);
    check("abort_pre_led", 32'(LED), 32'd55);
    tick(2);
    check("abort_in_write", 32'(DbgState), 32'(ST_WRITE));
    nReset = 1'b0;
    #1;
    check("abort_led",   32'(LED),      32'd0);
    check("abort_busy",  32'(Busy),     32'd0);
    check("abort_pc",    32'(Pc),       32'd0);
    check("abort_state", 32'(DbgState), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
